mmio_uart_tx: RTL

Memory-mapped UART transmitter on the CPU's system address/data bus, downstream of the CPU core. It takes the CPU's store cycles (`mem_write` with the accumulator value on `data_bus`) to a small register window and buffers the bytes in a FIFO. It serialises each byte as an 8-N-1 frame on `tx`. A status register is readable by the CPU, so firmware can poll for space before storing.

---
 rtl/mmio_uart_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8-N-1 UART transmitter with a small transmit FIFO and a STATUS register.
// Define UART_TX_PARITY_EN for an 8-E-1 frame with an even-parity bit before STOP.
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_bus,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [7:0]  rd_data,
  output logic        tx,
  output logic        tx_busy,
  output logic        irq
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]     STAT_ADDR = BASE_ADDR + 16'd1;
`ifdef UART_TX_PARITY_EN
  localparam logic            PAR_FLAG  = 1'b1;
`else
  localparam logic            PAR_FLAG  = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          overflow;
  logic          fifo_empty, fifo_full;
  logic          sel_data, sel_stat;
  logic          push_req, push, pop, bit_done;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  assign sel_data   = (addr_bus == BASE_ADDR);
  assign sel_stat   = (addr_bus == STAT_ADDR);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req   = mem_write && sel_data;
  // A full FIFO still takes a byte when the serialiser pops on the same edge.
  assign push       = push_req && (!fifo_full || pop);
  assign bit_done   = (cnt == CNT_MAX);
  assign tx_busy    = (state != IDLE) || !fifo_empty;
  assign irq        = !tx_busy;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: if (bit_done) state_next = DATA;
      DATA: begin
        if (bit_done && idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY: if (bit_done) state_next = STOP;
      STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:  tx = 1'b0;
      DATA:   tx = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = parity;
`endif
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data_bus;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      overflow <= 1'b0;
      rd_data  <= '0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;

      if (push_req && fifo_full && !pop) overflow <= 1'b1;
      else if (mem_write && sel_stat)    overflow <= 1'b0;

      if (mem_read && sel_stat)
        rd_data <= {PAR_FLAG, 3'b000, overflow, tx_busy, fifo_empty, fifo_full};
      else
        rd_data <= '0;

      if (pop) begin
        shreg  <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
        cnt    <= '0;
        idx    <= '0;
`ifdef UART_TX_PARITY_EN
        parity <= ^mem[rd_ptr[AW-1:0]];
`endif
      end else if (state != IDLE) begin
        if (bit_done) begin
          cnt <= '0;
          if (state == DATA) begin
            shreg <= {1'b0, shreg[7:1]};
            idx   <= idx + 3'd1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
